// File: rtl/alu_mdu.sv
// Handshaked execute unit: single-cycle ALU/branch compare plus an iterative
// radix-2 multiply/divide datapath shared behind a valid/ready interface.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_en,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
    OP_XOR    = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
    OP_SLT    = 5'd8,  OP_SLTU = 5'd9,  OP_BEQ  = 5'd10, OP_BNE  = 5'd11,
    OP_BLT    = 5'd12, OP_BGE  = 5'd13, OP_BLTU = 5'd14, OP_BGEU = 5'd15,
    OP_MUL    = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19,
    OP_DIV    = 5'd20, OP_DIVU = 5'd21, OP_REM  = 5'd22, OP_REMU = 5'd23
  } op_e;

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q;
  logic [4:0]        op_q;
  logic [XLEN-1:0]   result_q;
  logic              branch_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_q;
  logic              rneg_q;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CALC);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign branch_en = branch_q;

  // Single-cycle ALU and branch compare
  logic [XLEN-1:0] alu_res;
  logic            alu_br;
  logic [SHW-1:0]  shamt;
  logic            eq, lt_s, lt_u;

  always_comb begin
    shamt   = b[SHW-1:0];
    eq      = (a == b);
    lt_s    = ($signed(a) < $signed(b));
    lt_u    = (a < b);
    alu_res = '0;
    alu_br  = 1'b0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SLL:  alu_res = a << shamt;
      OP_SRL:  alu_res = a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, lt_u};
      OP_BEQ:  alu_br  = eq;
      OP_BNE:  alu_br  = ~eq;
      OP_BLT:  alu_br  = lt_s;
      OP_BGE:  alu_br  = ~lt_s;
      OP_BLTU: alu_br  = lt_u;
      OP_BGEU: alu_br  = ~lt_u;
      default: ;
    endcase
  end

  // Operand conditioning for multiply/divide at accept
  logic            is_mdu, is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    is_mdu   = op[4] & ~op[3];
    is_div   = is_mdu & op[2];
    sgn_a    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    sgn_b    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg    = sgn_a & a[XLEN-1];
    b_neg    = sgn_b & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = is_div && (b == '0);
    div_ovf  = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);
    // op[1] distinguishes remainder from quotient within 20..23
    if (div_zero)     spec_res = op[1] ? a : '1;
    else if (div_ovf) spec_res = op[1] ? '0 : MIN_NEG;
    else              spec_res = alu_res;
  end

  // One radix-2 step: acc = {hi, lo}; multiply shifts right, divide shifts left
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_nx, prod;
  logic [XLEN-1:0]   quo, rem, fin_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) acc_nx = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_nx = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_nx = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod = neg_q ? -acc_nx : acc_nx;
    quo  = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
    rem  = rneg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                       fin_res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = quo;
      OP_REM, OP_REMU:              fin_res = rem;
      default:                      fin_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      result_q <= '0;
      branch_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          op_q <= op;
          if (is_mdu && !div_zero && !div_ovf) begin
            acc_q   <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
            opnd_q  <= is_div ? b_mag : a_mag;
            neg_q   <= a_neg ^ b_neg;
            rneg_q  <= a_neg;
            cnt_q   <= CW'(XLEN);
            state_q <= CALC;
          end else begin
            result_q <= spec_res;
            branch_q <= alu_br;
            state_q  <= DONE;
          end
        end
        CALC: begin
          acc_q <= acc_nx;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_q <= fin_res;
            branch_q <= 1'b0;
            state_q  <= DONE;
          end
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: vector table at XLEN=32, handshake/backpressure/
// reset corner sequences, and a short XLEN=16 instance.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, branch_en, busy;
  logic [4:0]  op;
  logic [31:0] a, b, result;

  logic        in_valid16, in_ready16, out_valid16, out_ready16, branch_en16, busy16;
  logic [4:0]  op16;
  logic [15:0] a16, b16, result16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_en(branch_en), .busy(busy)
  );

  alu_mdu #(.XLEN(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
    .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
    .branch_en(branch_en16), .busy(busy16)
  );

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] r, input logic br, input int lat);
    vec_t v;
    v.op = o; v.a = va; v.b = vb; v.res = r; v.br = br; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one op on the 32-bit unit with out_ready high; operands are scrambled
  // right after the accept edge.
  task automatic run_op(input logic [4:0] o, input logic [31:0] va, input logic [31:0] vb,
                        output logic [31:0] r, output logic br, output int lat, output int bcnt);
    @(negedge clk);
    op = o; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = $urandom; b = $urandom; op = 5'($urandom);
    lat = 1; bcnt = 0;
    while (!out_valid && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    r = result; br = branch_en;
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic [4:0] o, input logic [15:0] va, input logic [15:0] vb,
                       output logic [15:0] r, output int lat, output int bcnt);
    @(negedge clk);
    op16 = o; a16 = va; b16 = vb; in_valid16 = 1'b1;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1; bcnt = 0;
    while (!out_valid16 && lat < 100) begin
      if (busy16) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    r = result16;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] r16;
    logic        br;
    int          lat, bcnt, guard;

    add_vec(5'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1);
    add_vec(5'd1,  32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1);
    add_vec(5'd2,  32'hF0F0FF00, 32'h0FF0F0F0, 32'h00F0F000, 1'b0, 1);
    add_vec(5'd3,  32'hF0F0FF00, 32'h0FF0F0F0, 32'hFFF0FFF0, 1'b0, 1);
    add_vec(5'd4,  32'hF0F0FF00, 32'h0FF0F0F0, 32'hFF000FF0, 1'b0, 1);
    add_vec(5'd5,  32'h1,        32'h3F,       32'h80000000, 1'b0, 1);
    add_vec(5'd6,  32'h80000000, 32'h4,        32'h08000000, 1'b0, 1);
    add_vec(5'd7,  32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1);
    add_vec(5'd8,  32'hFFFFFFFE, 32'h1,        32'h1,        1'b0, 1);
    add_vec(5'd9,  32'hFFFFFFFE, 32'h1,        32'h0,        1'b0, 1);
    add_vec(5'd10, 32'h5,        32'h5,        32'h0,        1'b1, 1);
    add_vec(5'd11, 32'h5,        32'h5,        32'h0,        1'b0, 1);
    add_vec(5'd12, 32'hFFFFFFFE, 32'h1,        32'h0,        1'b1, 1);
    add_vec(5'd13, 32'hFFFFFFFE, 32'h1,        32'h0,        1'b0, 1);
    add_vec(5'd14, 32'hFFFFFFFE, 32'h1,        32'h0,        1'b0, 1);
    add_vec(5'd15, 32'hFFFFFFFE, 32'h1,        32'h0,        1'b1, 1);
    add_vec(5'd17, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33);
    add_vec(5'd16, 32'h80000000, 32'h80000000, 32'h0,        1'b0, 33);
    add_vec(5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33);
    add_vec(5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
    add_vec(5'd16, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 33);
    add_vec(5'd20, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 1'b0, 33);
    add_vec(5'd22, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 1'b0, 33);
    add_vec(5'd20, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 33);
    add_vec(5'd22, 32'h7,        32'hFFFFFFFE, 32'h1,        1'b0, 33);
    add_vec(5'd21, 32'd100,      32'd7,        32'd14,       1'b0, 33);
    add_vec(5'd23, 32'd100,      32'd7,        32'd2,        1'b0, 33);
    add_vec(5'd21, 32'd100,      32'h0,        32'hFFFFFFFF, 1'b0, 1);
    add_vec(5'd23, 32'd100,      32'h0,        32'd100,      1'b0, 1);
    add_vec(5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b0, 1);
    add_vec(5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    add_vec(5'd25, 32'h5,        32'h5,        32'h0,        1'b0, 1);
    add_vec(5'd31, 32'h1,        32'h1,        32'h0,        1'b0, 1);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; op16 = '0; a16 = '0; b16 = '0;
    #12;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready",  64'(in_ready),  64'd1);
    chk("reset busy",      64'(busy),      64'd0);
    chk("reset result",    64'(result),    64'd0);
    chk("reset branch_en", 64'(branch_en), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD handshake timing
    @(negedge clk);
    op = 5'd0; a = 32'hFFFFFFFF; b = 32'h1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("add t1 out_valid", 64'(out_valid), 64'd1);
    chk("add t1 in_ready",  64'(in_ready),  64'd0);
    chk("add t1 result",    64'(result),    64'd0);
    @(posedge clk);
    #1;
    chk("add t2 in_ready",  64'(in_ready),  64'd1);
    chk("add t2 out_valid", 64'(out_valid), 64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, br, lat, bcnt);
      chk($sformatf("vec%0d op%0d result", i, vecs[i].op), 64'(r), 64'(vecs[i].res));
      chk($sformatf("vec%0d op%0d branch", i, vecs[i].op), 64'(br), 64'(vecs[i].br));
      chk($sformatf("vec%0d op%0d latency", i, vecs[i].op), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d op%0d busy cycles", i, vecs[i].op), 64'(bcnt),
          64'((vecs[i].lat == 33) ? 32 : 0));
    end

    // Backpressure: DIVU 100/7 held while out_ready is low
    @(negedge clk);
    op = 5'd21; a = 32'd100; b = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    op = 5'd0; a = 32'd1; b = 32'd1;
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("bp out_valid reached", 64'(out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp c%0d result", c),    64'(result),    64'd14);
      chk($sformatf("bp c%0d out_valid", c), 64'(out_valid), 64'd1);
      chk($sformatf("bp c%0d in_ready", c),  64'(in_ready),  64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release in_ready",  64'(in_ready),  64'd1);
    chk("bp release out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset during CALC of a MUL
    @(negedge clk);
    op = 5'd16; a = 32'h80000000; b = 32'h80000000; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    chk("pre-reset busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst busy",      64'(busy),      64'd0);
    chk("async rst result",    64'(result),    64'd0);
    chk("async rst in_ready",  64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(5'd0, 32'd2, 32'd3, r, br, lat, bcnt);
    chk("post-reset add result",  64'(r),   64'd5);
    chk("post-reset add latency", 64'(lat), 64'd1);

    // XLEN = 16 instance
    run16(5'd0, 16'hFFFF, 16'h1, r16, lat, bcnt);
    chk("x16 add result",  64'(r16), 64'h0);
    chk("x16 add latency", 64'(lat), 64'd1);
    run16(5'd17, 16'h8000, 16'h8000, r16, lat, bcnt);
    chk("x16 mulh result",  64'(r16),  64'h4000);
    chk("x16 mulh latency", 64'(lat),  64'd17);
    chk("x16 mulh busy",    64'(bcnt), 64'd16);
    run16(5'd16, 16'h8000, 16'h8000, r16, lat, bcnt);
    chk("x16 mul result",  64'(r16), 64'h0);
    chk("x16 mul latency", 64'(lat), 64'd17);
    run16(5'd20, 16'hFFF9, 16'h2, r16, lat, bcnt);
    chk("x16 div result", 64'(r16), 64'hFFFD);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked successor to the single-cycle execute ALU. It adds the full RV32 branch-compare set and the RV32M multiply/divide/remainder operations. Multiply/divide run as a shared iterative radix-2 datapath behind a valid/ready interface, so the core's execute stage can stall on long operations. Single-cycle ALU operations keep the original encodings 0–10.

## Interface
- XLEN, 32, operand/result width; must be ≥ 8 and a power of 2.
- SHW, $clog2(XLEN), derived shift-amount width; not overridden.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request present
- in_ready  out  1  block can accept a request; high only in IDLE
- op  in  5  operation code
- a  in  XLEN  operand 1 (rs1)
- b  in  XLEN  operand 2 (rs2/imm)
- out_valid  out  1  result/branch_en valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  registered result
- branch_en  out  1  registered branch-taken flag
- busy  out  1  high in CALC

## Operation
- Ops 0–9: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU. Shifts use b[SHW-1:0].
- Branch ops set branch_en and force result = 0:
  - 10 BEQ, 11 BNE, 12 BLT (signed), 13 BGE (signed), 14 BLTU, 15 BGEU.
- 16 MUL returns the low XLEN bits. 17 MULH, 18 MULHSU (a signed, b unsigned) and 19 MULHU return the high XLEN bits of the 2·XLEN product.
- 20 DIV, 21 DIVU, 22 REM, 23 REMU.
- Ops 24–31: result = 0, branch_en = 0, latency 1 (no error flag).
- FSM states: IDLE, CALC, DONE.
  - IDLE: a transfer occurs when in_valid && in_ready; operands and op are captured.
  - Ops 0–15 and 24–31: result computed at accept, go to DONE.
  - Ops 16–23: take operand magnitudes per signedness and record result sign, init counter = XLEN, go to CALC.
  - Divide special cases are resolved at accept and go directly to DONE:
    - Divisor 0: quotient = all ones (DIV and DIVU); remainder = a.
    - DIV/REM with a = most-negative and b = −1: quotient = most-negative, remainder = 0.
  - CALC: one iteration per cycle; the counter decrements. At counter 1 the result is finalised (sign-corrected, hi/lo selected) and the FSM goes to DONE.
    - Multiply: shift-add on an unsigned 2·XLEN accumulator.
    - Divide: restoring, one quotient bit per cycle.
    - Negation sign rules:
      - Product: negated if sign(a) ≠ sign(b) for the signed operand set.
      - Quotient: negated if the signs differ.
      - Remainder: takes the sign of the dividend.
  - DONE: out_valid = 1; result and branch_en are held stable until out_ready, then return to IDLE.
- in_ready = (state == IDLE); no request is accepted in CALC or DONE.
- Operand inputs are ignored outside an accept cycle.

## Timing
- Reset values (async, asserted): state IDLE, out_valid 0, result 0, branch_en 0, busy 0, counter 0, in_ready 1.
- Latency is counted from the accept edge to the edge where out_valid rises.
  - Single-cycle ops and divide special cases: out_valid is high in the cycle after accept (1 cycle).
  - Multiply/divide: XLEN+1 cycles (33 for XLEN = 32); busy is high for exactly XLEN cycles.
- Throughput: at best one result per 2 cycles (accept, DONE+out_ready). in_ready rises the cycle after the out_valid && out_ready handshake.
- Backpressure: out_valid, result and branch_en must not change while out_valid && !out_ready.
- Reset asserted mid-CALC or mid-DONE: the operation is abandoned and all outputs are at reset values immediately (asynchronously). The first accept is possible on the first clock edge after rst_n deasserts.
- All arithmetic is modulo 2^XLEN except the internal 2·XLEN product. SLTU/BLTU/BGEU/DIVU/REMU/MULHU are pure unsigned.

## Test plan
- ADD a=0xFFFFFFFF, b=1, out_ready=1: out_valid 1 cycle after accept, result=0, branch_en=0; in_ready returns high 2 cycles after accept.
- BLT a=0xFFFFFFFE (−2), b=1: branch_en=1, result=0. BLTU with the same operands: branch_en=0. BGEU: branch_en=1.
- MULH a=0x80000000, b=0x80000000: busy for 32 cycles, out_valid at cycle 33, result=0x40000000. MUL with the same operands: result=0. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF: result=0xFFFFFFFF.
- DIV a=−7 (0xFFFFFFF9), b=2: result=0xFFFFFFFD (−3). REM with the same operands: result=0xFFFFFFFF (−1). DIVU a=100, b=0: result=0xFFFFFFFF at latency 1. REM a=0x80000000, b=0xFFFFFFFF: result=0 at latency 1.
- Backpressure: DIVU 100/7 with out_ready=0 for 5 cycles after out_valid: result=14 held, in_ready=0 and in_valid requests ignored; out_ready=1 completes the transfer and in_ready rises the next cycle.
- Pull rst_n low at CALC cycle 10 of a MUL: out_valid=0, busy=0, result=0 immediately. After release, ADD 2+3 returns 5 at latency 1. Repeat the ADD and MUL directed cases with XLEN=16 and check the MUL latency is 17.
